// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM states and the multi-cycle decode helper shared by
// the alu_mdu top level and its testbench.
// Optional feature macro: ALU_MDU_DIV_EN (enables the divide op codes).
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_XNOR  = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_MULT  = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    // Multiply always iterates; divide only exists when the divider is built in.
    function automatic logic isMultiCycle(input logic [3:0] op);
`ifdef ALU_MDU_DIV_EN
        return (op == OP_MULTU) || (op == OP_MULT) || (op == OP_DIVU) || (op == OP_DIV);
`else
        return (op == OP_MULTU) || (op == OP_MULT);
`endif
    endfunction

endpackage

// File: rtl/mdu_core.sv
// mdu_core: unsigned iterative datapath. One step per cycle: shift-add
// multiply (acc:low shifts right) or restoring divide (acc:low shifts left).
// After WIDTH steps hiOut/loOut hold product high/low or remainder/quotient.
module mdu_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             isDiv,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] hiOut,
    output logic [WIDTH-1:0] loOut
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] low_q, low_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Next-state of the iteration registers: load operands, or take one step.
    always_comb begin
        acc_d     = acc_q;
        low_d     = low_q;
        operand_d = operand_q;
        sum       = {1'b0, acc_q} + (low_q[0] ? {1'b0, operand_q} : '0);
        shifted   = {acc_q, low_q[WIDTH-1]};
        diff      = shifted - {1'b0, operand_q};
        if (load) begin
            acc_d     = '0;
            low_d     = opA;
            operand_d = opB;
        end else if (step) begin
            if (isDiv) begin
                if (!diff[WIDTH]) begin
                    acc_d = diff[WIDTH-1:0];
                    low_d = {low_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = shifted[WIDTH-1:0];
                    low_d = {low_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = sum[WIDTH:1];
                low_d = {sum[0], low_q[WIDTH-1:1]};
            end
        end
    end

    // Iteration register bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            low_q     <= '0;
            operand_q <= '0;
        end else begin
            acc_q     <= acc_d;
            low_q     <= low_d;
            operand_q <= operand_d;
        end
    end

    assign hiOut = acc_q;
    assign loOut = low_q;

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: registered single-cycle ALU plus iterative multiply/divide unit
// with HI/LO registers and a start/busy/done handshake.
// Optional feature macro: ALU_MDU_DIV_EN (divider datapath, ops 1010/1011,
// div_by_zero flag). Without it, those op codes act as undefined op codes.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             negLo_q, negLo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
`ifdef ALU_MDU_DIV_EN
    logic             isDiv_q, isDiv_d;
    logic             negHi_q, negHi_d;
    logic             bZero_q, bZero_d;
    logic [WIDTH-1:0] aSave_q, aSave_d;
    logic             dbz_q, dbz_d;
`endif

    logic             coreLoad;
    logic             coreStep;
    logic             coreIsDiv;
    logic             signedOp;
    logic [WIDTH-1:0] magA, magB;
    logic [WIDTH-1:0] coreHi, coreLo;
    logic [WIDTH:0]   addSum, subDiff;
    logic             addOvf, subOvf;
    logic [2*WIDTH-1:0] prod, prodNeg;

    assign signedOp = (op == OP_MULT) || (op == OP_DIV);
    assign magA     = (signedOp && a[WIDTH-1]) ? -a : a;
    assign magB     = (signedOp && b[WIDTH-1]) ? -b : b;
    assign addSum   = {1'b0, a} + {1'b0, b};
    assign subDiff  = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    assign addOvf   = (a[WIDTH-1] == b[WIDTH-1]) && (addSum[WIDTH-1] != a[WIDTH-1]);
    assign subOvf   = (a[WIDTH-1] != b[WIDTH-1]) && (subDiff[WIDTH-1] != a[WIDTH-1]);
    assign prod     = {coreHi, coreLo};
    assign prodNeg  = -prod;
    assign coreStep = (state_q == RUN);
`ifdef ALU_MDU_DIV_EN
    assign coreIsDiv = isDiv_q;
`else
    assign coreIsDiv = 1'b0;
`endif

    mdu_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (coreLoad),
        .step  (coreStep),
        .isDiv (coreIsDiv),
        .opA   (magA),
        .opB   (magB),
        .hiOut (coreHi),
        .loOut (coreLo)
    );

    // FSM next state, single-cycle ALU results and the FIX-stage write-back.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        negLo_d  = negLo_q;
        result_d = result_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        coreLoad = 1'b0;
`ifdef ALU_MDU_DIV_EN
        isDiv_d  = isDiv_q;
        negHi_d  = negHi_q;
        bZero_d  = bZero_q;
        aSave_d  = aSave_q;
        dbz_d    = dbz_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (isMultiCycle(op)) begin
                        state_d  = RUN;
                        count_d  = CW'(WIDTH);
                        coreLoad = 1'b1;
                        negLo_d  = signedOp && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ALU_MDU_DIV_EN
                        isDiv_d  = (op == OP_DIVU) || (op == OP_DIV);
                        negHi_d  = signedOp && a[WIDTH-1];
                        bZero_d  = (b == '0);
                        aSave_d  = a;
`endif
                    end else begin
                        done_d  = 1'b1;
                        carry_d = 1'b0;
                        ovf_d   = 1'b0;
                        case (op)
                            OP_AND:  result_d = a & b;
                            OP_OR:   result_d = a | b;
                            OP_XNOR: result_d = ~(a ^ b);
                            OP_ADD: begin
                                result_d = addSum[WIDTH-1:0];
                                carry_d  = addSum[WIDTH];
                                ovf_d    = addOvf;
                            end
                            OP_SUB: begin
                                result_d = subDiff[WIDTH-1:0];
                                carry_d  = ~subDiff[WIDTH];
                                ovf_d    = subOvf;
                            end
                            OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, subDiff[WIDTH-1] ^ subOvf};
                            default: result_d = '0;
                        endcase
                    end
                end
            end
            RUN: begin
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                carry_d = 1'b0;
                ovf_d   = 1'b0;
`ifdef ALU_MDU_DIV_EN
                if (isDiv_q) begin
                    if (bZero_q) begin
                        lo_d  = '1;
                        hi_d  = aSave_q;
                        dbz_d = 1'b1;
                    end else begin
                        lo_d  = negLo_q ? -coreLo : coreLo;
                        hi_d  = negHi_q ? -coreHi : coreHi;
                        dbz_d = 1'b0;
                    end
                end else
`endif
                begin
                    {hi_d, lo_d} = negLo_q ? prodNeg : prod;
                end
                result_d = lo_d;
            end
            default: state_d = IDLE;
        endcase
        zero_d = (result_d == '0);
    end

    // Control and output register bank; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            negLo_q  <= 1'b0;
            result_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            zero_q   <= 1'b1;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            negLo_q  <= negLo_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

`ifdef ALU_MDU_DIV_EN
    // Divide-only context captured at acceptance, plus the sticky divide flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isDiv_q <= 1'b0;
            negHi_q <= 1'b0;
            bZero_q <= 1'b0;
            aSave_q <= '0;
            dbz_q   <= 1'b0;
        end else begin
            isDiv_q <= isDiv_d;
            negHi_q <= negHi_d;
            bZero_q <= bZero_d;
            aSave_q <= aSave_d;
            dbz_q   <= dbz_d;
        end
    end
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    assign result    = result_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign zero      = zero_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: scoreboard bench for alu_mdu (WIDTH = 32). Stimulus pushes the
// expected response computed by a plain-arithmetic reference model; a monitor
// pops and compares whenever done is seen.
// Honours ALU_MDU_DIV_EN the same way the design does.
module tb_alu_mdu;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] result, hi, lo;
    logic         zero, carry_out, overflow, div_by_zero, busy, done;

    alu_mdu #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .result      (result),
        .hi          (hi),
        .lo          (lo),
        .zero        (zero),
        .carry_out   (carry_out),
        .overflow    (overflow),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .done        (done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Rising-edge counter, read only on falling edges.
    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hiV;
        logic [31:0] loV;
        logic        z;
        logic        c;
        logic        v;
        logic        dbz;
        int          lat;
        int          issue;
    } exp_t;

    exp_t        sbQ[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;
    logic        mDbz = 1'b0;

    // One comparison: count it, report a mismatch.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference model: behaviour straight from the operation rules.
    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      sx, sy, s, q, r;
        longint unsigned p;
        logic [63:0] pv;
        logic        isDivOp;
        sx = $signed(x);
        sy = $signed(y);
        e.res = '0; e.hiV = mHi; e.loV = mLo; e.c = 1'b0; e.v = 1'b0;
        e.dbz = mDbz; e.lat = 0; e.issue = 0;
`ifdef ALU_MDU_DIV_EN
        isDivOp = (o == OP_DIVU) || (o == OP_DIV);
`else
        isDivOp = 1'b0;
`endif
        if (o == OP_AND) e.res = x & y;
        else if (o == OP_OR) e.res = x | y;
        else if (o == OP_XNOR) e.res = ~(x ^ y);
        else if (o == OP_ADD) begin
            p = longint'({32'b0, x}) + longint'({32'b0, y});
            pv = p;
            e.res = pv[31:0];
            e.c = pv[32];
            s = sx + sy;
            e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (o == OP_SUB) begin
            e.res = x - y;
            e.c = (x < y);
            s = sx - sy;
            e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (o == OP_SLT) e.res = (sx < sy) ? 32'd1 : 32'd0;
        else if (o == OP_MULTU || o == OP_MULT) begin
            if (o == OP_MULTU) pv = {32'b0, x} * {32'b0, y};
            else pv = sx * sy;
            e.hiV = pv[63:32];
            e.loV = pv[31:0];
            e.res = e.loV;
            e.lat = W + 1;
        end else if (isDivOp) begin
            e.lat = W + 1;
            if (y == 0) begin
                e.loV = '1; e.hiV = x; e.dbz = 1'b1;
            end else begin
                e.dbz = 1'b0;
                if (o == OP_DIVU) begin
                    e.loV = x / y; e.hiV = x % y;
                end else begin
                    q = sx / sy; r = sx % sy;
                    e.loV = q[31:0]; e.hiV = r[31:0];
                end
            end
            e.res = e.loV;
        end
        e.z = (e.res == 0);
        return e;
    endfunction

    // Issue one accepted request at a falling edge and record its expectation.
    task automatic applyStimulus(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        int   waitN;
        @(negedge clk);
        waitN = 0;
        while (busy && waitN < 200) begin
            @(negedge clk);
            waitN++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("[TB] FAIL busy_timeout: busy still 1 after %0d cycles", waitN);
        end
        op = o; a = x; b = y; start = 1'b1;
        e = model(o, x, y);
        e.issue = cycle;
        mHi = e.hiV; mLo = e.loV; mDbz = e.dbz;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom; op = 4'($urandom);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sbQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done: done=1 with no request outstanding");
            end else begin
                e = sbQ.pop_front();
                checkOutput("result", 64'(result), 64'(e.res));
                checkOutput("hi", 64'(hi), 64'(e.hiV));
                checkOutput("lo", 64'(lo), 64'(e.loV));
                checkOutput("zero", 64'(zero), 64'(e.z));
                checkOutput("carry_out", 64'(carry_out), 64'(e.c));
                checkOutput("overflow", 64'(overflow), 64'(e.v));
                checkOutput("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                checkOutput("latency", 64'(cycle - e.issue - 1), 64'(e.lat));
                checkOutput("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    // Main sequence: reset, directed plan, ignore-while-busy, mid-run reset, random.
    initial begin
        int          bc;
        int          waitN;
        logic [3:0]  opList[12];
        logic [31:0] ra, rb;
        opList = '{OP_AND, OP_OR, OP_XNOR, OP_ADD, OP_SUB, OP_SLT,
                   OP_MULTU, OP_MULT, OP_DIVU, OP_DIV, 4'b0011, 4'b1111};

        #12;
        checkOutput("reset_result", 64'(result), 64'd0);
        checkOutput("reset_hi", 64'(hi), 64'd0);
        checkOutput("reset_lo", 64'(lo), 64'd0);
        checkOutput("reset_zero", 64'(zero), 64'd1);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        applyStimulus(OP_SUB, 32'd5, 32'd7);
        applyStimulus(OP_SLT, 32'h8000_0000, 32'd1);
        applyStimulus(OP_AND, 32'h0000_F0F0, 32'h0000_0FF0);
        applyStimulus(OP_XNOR, 32'h1234_5678, 32'h1234_5678);
        applyStimulus(OP_MULT, -32'sd3, 32'd7);
        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus(OP_DIV, -32'sd7, 32'd2);
        applyStimulus(OP_DIVU, 32'd100, 32'd0);
        applyStimulus(OP_DIVU, 32'd9, 32'd3);
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        applyStimulus(OP_DIV, 32'd8, 32'd2);
        applyStimulus(4'b1110, 32'd1, 32'd2);

        // MULT with an ADD request held during busy; busy spans 33 cycles.
        applyStimulus(OP_MULT, 32'd12345, -32'sd678);
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (i == 3) begin
                op = OP_ADD; a = 32'd1; b = 32'd1; start = 1'b1;
            end
            if (i == 6) start = 1'b0;
        end
        checkOutput("mult_busy_cycles", 64'(bc), 64'(W + 1));

        // Reset during the tenth cycle of a MULT.
        applyStimulus(OP_MULT, 32'd1000, 32'd3000);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_done", 64'(done), 64'd0);
        checkOutput("midrst_hi", 64'(hi), 64'd0);
        checkOutput("midrst_lo", 64'(lo), 64'd0);
        checkOutput("midrst_zero", 64'(zero), 64'd1);
        checkOutput("midrst_result", 64'(result), 64'd0);
        sbQ.delete();
        mHi = '0; mLo = '0; mDbz = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(OP_MULTU, 32'd6, 32'd7);
        applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'd1);

        // Randomised mix, including divide corner operands.
        for (int n = 0; n < 60; n++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            applyStimulus(opList[$urandom_range(0, 11)], ra, rb);
        end

        waitN = 0;
        while (sbQ.size() != 0 && waitN < 200) begin
            @(negedge clk);
            waitN++;
        end
        if (sbQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout: %0d responses outstanding, expected 0", sbQ.size());
        end
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, clocked successor to the single-cycle 32-bit ALU for the MIPS datapath. It performs the same logic, add, sub, SLT and XNOR operations with registered result and flags, and adds an iterative multiply/divide unit writing HI/LO registers. A start/busy/done handshake lets the control unit stall on multi-cycle operations. It sits in the execute stage, in place of the combinational ALU, for the multi-cycle core.

## Interface
- WIDTH, 32: operand, result, HI and LO width; must be ≥ 4.
- clk  in  1: clock; all state changes on rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- start  in  1: request; sampled only while busy = 0.
- op  in  4: operation code (see Operation).
- a, b  in  WIDTH: operands; captured on the accepting edge.
- result  out  WIDTH: registered result; reset 0.
- hi, lo  out  WIDTH: multiply/divide registers; reset 0.
- zero  out  1: result == 0; reset 1.
- carry_out, overflow  out  1: add/sub flags; reset 0.
- div_by_zero  out  1: last divide had b == 0; reset 0.
- busy  out  1: multi-cycle operation in progress; reset 0.
- done  out  1: one-cycle completion pulse; reset 0.

## Operation
- Single-cycle ops:
  - 0000 AND, 0001 OR, 1100 XNOR.
  - 0010 ADD: carry_out = adder carry.
  - 0110 SUB: a + ~b + 1; carry_out = inverted adder carry, i.e. borrow.
  - 0111 SLT: result = {0…, sign(a−b) ^ overflow(a−b)}.
  - overflow is the signed overflow for ADD/SUB; 0 for every other op.
  - carry_out is 0 for every other op.
- Multi-cycle ops:
  - 1000 MULTU and 1001 MULT: {hi,lo} = a*b, 2·WIDTH bits.
  - 1010 DIVU and 1011 DIV: lo = quotient, hi = remainder.
  - For these ops, result = lo at completion, and zero tracks that value.
- Signed ops work on magnitudes, then apply the sign fix:
  - product negative iff sign(a) ≠ sign(b);
  - quotient truncates toward zero;
  - remainder takes the sign of a.
- Divide by zero: lo = all ones, hi = a, div_by_zero = 1. Any other divide clears div_by_zero.
- DIV of −2^(WIDTH−1) by −1: lo = −2^(WIDTH−1), hi = 0, no flag.
- Undefined op codes: result 0, flags 0, hi/lo unchanged, done still pulses.
- FSM states:
  - IDLE → RUN on start with a multi-cycle op; otherwise stays in IDLE, and a single-cycle op completes there.
  - RUN runs WIDTH iterations (shift-add multiply, restoring divide) with a down-counter; → FIX when the count hits 0.
  - FIX applies the sign fix, writes hi/lo/result/flags, pulses done; → IDLE.
- hi/lo change only in FIX. Single-cycle ops never touch them.

## Timing
- Edge E samples start = 1 with busy = 0.
- Single-cycle op: result and flags update at E; done = 1 for the cycle after E; busy stays 0.
- Multi-cycle op:
  - busy rises at E;
  - RUN iterations occur at E+1 … E+WIDTH;
  - FIX at E+WIDTH+1 writes outputs, drops busy and raises done for one cycle.
  - Latency is WIDTH+1 cycles (33 for WIDTH = 32).
- start while busy = 1 is ignored; no queuing.
- Back-to-back: start is accepted in the same cycle done is high.
- Operands are latched at E; changing a/b/op afterwards has no effect.
- rst_n low at any time, including mid-RUN, immediately forces all outputs to their reset values and the FSM to IDLE. The aborted operation is lost.

## Configuration
- ALU_MDU_DIV_EN defined: the divider datapath and op codes 1010/1011 are present.
- ALU_MDU_DIV_EN undefined:
  - 1010/1011 behave as undefined op codes (single cycle, result 0, hi/lo unchanged, no busy);
  - div_by_zero is tied to 0;
  - the multiplier is unaffected.

## Structure
- Package alu_pkg holds:
  - op code localparams (OP_AND … OP_DIV);
  - FSM state enum (IDLE, RUN, FIX);
  - a helper for the is-multi-cycle decode.
- Sub-module mdu_core is the iteration datapath: unsigned shift-add multiply / restoring divide, WIDTH-parameterised, with load/step controls.
- The top level owns the FSM, sign handling, the single-cycle ALU path and the output registers.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow 1, carry_out 0, done one cycle after start, busy never high.
- SUB 5 − 7 → 0xFFFFFFFE, carry_out 1; SLT a = 0x80000000, b = 1 → result 1; AND 0xF0F0 & 0x0FF0 → 0x00F0, zero 0.
- MULT −3 × 7 → hi 0xFFFFFFFF, lo 0xFFFFFFEB, busy high 33 cycles, done exactly 33 cycles after the start edge; MULTU 0xFFFFFFFF² → hi 0xFFFFFFFE, lo 0x00000001.
- DIV −7 / 2 → lo 0xFFFFFFFD, hi 0xFFFFFFFF; DIVU 100 / 0 → lo 0xFFFFFFFF, hi 100, div_by_zero 1; next DIVU 9 / 3 → lo 3, hi 0, div_by_zero 0.
- start with ADD while MULT is busy → ignored, MULT result intact; rst_n low at cycle 10 of a MULT → busy/done/hi/lo 0 immediately, zero 1, next start accepted normally.
- Build without ALU_MDU_DIV_EN: DIV 8 / 2 → single-cycle done, result 0, hi/lo unchanged, busy 0.
